// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers raster position, line/frame lengths and lock status
// from an active-low HS/VS pair that is asynchronous to clk.
module vga_sync_rx #(
  parameter int HS_TS       = 800,
  parameter int VS_TS       = 525,
  parameter int HS_OFFSET   = 144,
  parameter int VS_OFFSET   = 35,
  parameter int NUM_COLS    = 640,
  parameter int NUM_ROWS    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  output logic [9:0]  rx_row,
  output logic [9:0]  rx_col,
  output logic        rx_active,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        lock_lost,
  output logic [1:0]  lock_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] HS_TS_W   = 11'(HS_TS);
  localparam logic [10:0] VS_TS_W   = 11'(VS_TS);
  localparam logic [9:0]  HS_OFF_W  = 10'(HS_OFFSET);
  localparam logic [9:0]  VS_OFF_W  = 10'(VS_OFFSET);
  localparam logic [9:0]  COLS_W    = 10'(NUM_COLS);
  localparam logic [9:0]  ROWS_W    = 10'(NUM_ROWS);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  state_t      state;
  logic        hs_meta, hs_s, vs_meta, vs_s;
  logic        hs_prev, vs_at_hs;
  logic [9:0]  hcnt, vcnt;
  logic [3:0]  good_cnt;
  logic        frame_bad;

  logic        hs_edge, fs, line_bad, frame_good, hsat, vsat;
  logic [10:0] hcnt_inc, vcnt_inc;
  logic [3:0]  good_inc;

  // Edge, frame-start and line/frame quality decode from registered state.
  // A line check and a frame start on the same edge both see this line.
  always_comb begin
    hcnt_inc   = {1'b0, hcnt} + 11'd1;
    vcnt_inc   = {1'b0, vcnt} + 11'd1;
    good_inc   = good_cnt + 4'd1;
    hs_edge    = pix_en && !hs_s && hs_prev;
    fs         = hs_edge && !vs_s && vs_at_hs;
    line_bad   = hs_edge && (state != SEARCH) && (hcnt_inc != HS_TS_W);
    frame_good = !(frame_bad || line_bad) && (vcnt_inc == VS_TS_W);
    hsat       = (hcnt == 10'd1023);
    vsat       = (vcnt == 10'd1023);
  end

  // Output decode; every term comes from registers that move only on pix_en.
  always_comb begin
    locked     = (state == LOCKED);
    lock_state = state;
    rx_row     = vcnt - VS_OFF_W;
    rx_col     = hcnt - HS_OFF_W;
    rx_active  = locked && (rx_row < ROWS_W) && (rx_col < COLS_W);
  end

  // Two-flop synchronizers for the asynchronous sync inputs (idle high).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hs_meta <= 1'b1;
      hs_s    <= 1'b1;
      vs_meta <= 1'b1;
      vs_s    <= 1'b1;
    end else begin
      hs_meta <= HS;
      hs_s    <= hs_meta;
      vs_meta <= VS;
      vs_s    <= vs_meta;
    end
  end

  // Horizontal/vertical counters and measured lengths, advanced on pix_en.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hs_prev     <= 1'b1;
      vs_at_hs    <= 1'b1;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      line_len    <= 11'd0;
      frame_lines <= 11'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fs;
      if (pix_en) begin
        hs_prev <= hs_s;
        if (hs_edge) begin
          vs_at_hs <= vs_s;
          line_len <= hcnt_inc;
          hcnt     <= 10'd0;
          if (fs) begin
            frame_lines <= vcnt_inc;
            vcnt        <= 10'd0;
          end else if (!vsat) begin
            vcnt <= vcnt + 10'd1;
          end
        end else if (!hsat) begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Lock FSM: SEARCH waits for a frame start, CHECK counts good frames,
  // LOCKED drops back on any timing fault with a one-clk lock_lost pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= SEARCH;
      good_cnt  <= 4'd0;
      frame_bad <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (pix_en) begin
        case (state)
          SEARCH: begin
            if (fs) begin
              state     <= CHECK;
              good_cnt  <= 4'd0;
              frame_bad <= 1'b0;
            end
          end
          CHECK: begin
            if (fs) begin
              frame_bad <= 1'b0;
              if (frame_good) begin
                good_cnt <= good_inc;
                if (good_inc == LOCK_N) state <= LOCKED;
              end else begin
                good_cnt <= 4'd0;
              end
            end else if (hsat || vsat) begin
              frame_bad <= 1'b1;
              good_cnt  <= 4'd0;
            end else if (line_bad) begin
              frame_bad <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_bad || (fs && !frame_good) || hsat || vsat) begin
              state     <= SEARCH;
              lock_lost <= 1'b1;
            end else if (fs) begin
              frame_bad <= 1'b0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
